muldiv_sequencer: RTL and testbench
===================================

MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and HI/LO width.
REQ-002 SHALL have port Clk, input, 1 bit: rising-edge clock, the only clock.
REQ-003 SHALL have port Rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: EX stage issues a multiply/divide op.
REQ-005 SHALL have port op, input, 2 bits: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports opA and opB, input, WIDTH bits each: rs and rt values.
REQ-007 SHALL have port flush, input, 1 bit: abort the in-flight op (branch/jump flush).
REQ-008 SHALL have port hilo_read, input, 1 bit: the ID stage holds mfhi/mflo, or a new mult/div.
REQ-009 SHALL have port busy, output, 1 bit: an op is in flight.
REQ-010 SHALL have port stall, output, 1 bit: to the hazard unit; holds PC and IF/ID and bubbles control.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when HI/LO update.
REQ-012 SHALL have ports hi and lo, output, WIDTH bits each: architectural HI and LO registers.

Function
REQ-013 SHALL implement the FSM IDLE -> BUSY -> DONE -> IDLE.
REQ-014 SHALL accept start only in IDLE; latch the absolute values of the operands, op, sign flags and opB==0; load the counter with WIDTH-1.
REQ-015 SHALL perform one shift-add (multiply) or restoring-subtract (divide) iteration per BUSY cycle; BUSY SHALL last exactly WIDTH cycles.
REQ-016 SHALL, in DONE, apply sign correction, write hi/lo and pulse done.
REQ-017 SHALL make hi/lo visible in the cycle after DONE; total latency from the start edge is WIDTH+2 cycles.
REQ-018 SHALL produce, for MULT/MULTU, {hi,lo} = the 2*WIDTH-bit product.
REQ-019 SHALL produce, for DIV/DIVU, lo = quotient and hi = remainder.
REQ-020 SHALL truncate the signed quotient toward zero; the remainder SHALL take the sign of the dividend.
REQ-021 SHALL, for divide by zero, set lo = all ones and hi = opA, still taking full latency.
REQ-022 SHALL produce lo = 0x80000000 and hi = 0 for signed overflow (0x80000000 / -1, WIDTH=32).
REQ-023 SHALL assert busy in BUSY and DONE.
REQ-024 SHALL assert stall combinationally when busy and hilo_read; it SHALL deassert in the cycle hi/lo become valid.
REQ-025 SHALL ignore start while busy; the stall covers the requester (hilo_read asserted).
REQ-026 SHALL, on flush in BUSY or DONE, go to IDLE next cycle with hi/lo unchanged and no done pulse.
REQ-027 SHALL let flush win when start and flush are both high in IDLE; no op is accepted.
REQ-028 SHALL let flush win when flush is high in DONE; hi/lo are not written.
REQ-029 SHALL keep hi/lo unchanged except in DONE.

Reset
REQ-030 SHALL, while Rst_n is low, force state IDLE, counter 0, hi 0, lo 0, and busy, stall and done 0, asynchronously.
REQ-031 SHALL make Rst_n assertion mid-operation discard the op; the first start after release SHALL behave as from power-up.

Configuration
REQ-032 SHALL, with MULDIV_DIV_EN defined, implement DIV/DIVU as above.
REQ-033 SHALL, without MULDIV_DIV_EN, treat op 10/11 as a no-op: no state change, no stall, hi/lo unchanged; divider logic SHALL be absent.

Structure
REQ-034 SHALL take the op encodings, the FSM state enum and the divide-by-zero lo constant from the shared package muldiv_pkg.
REQ-035 SHALL put the single-iteration shift-add/subtract step in sub-module muldiv_step; the FSM, counter and sign logic SHALL stay in muldiv_sequencer.

Verification
REQ-036 SHALL cover: MULT opA=-3, opB=7 -> after 34 cycles hi=0xFFFFFFFF, lo=0xFFFFFFEB; done pulses once.
REQ-037 SHALL cover: DIVU 100/7 -> lo=14, hi=2; DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-038 SHALL cover: DIV 5/0 -> lo=0xFFFFFFFF, hi=5; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
REQ-039 SHALL cover: hilo_read held from cycle 3 -> stall high through DONE, low when hi/lo valid; a second start while busy is ignored.
REQ-040 SHALL cover: flush at BUSY cycle 10 -> IDLE next cycle, hi/lo keep prior values, no done.
REQ-041 SHALL cover: Rst_n low at BUSY cycle 20 -> all outputs 0 immediately; with MULDIV_DIV_EN undefined, a DIV start -> busy stays 0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared definitions for the multiply/divide sequencer.
//   op_e    : op encodings carried on the 2-bit op port
//   state_e : sequencer FSM states
//   DIV0_LO : lo result for divide by zero (sliced down to WIDTH; WIDTH <= MAX_WIDTH)
package muldiv_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  localparam int                   MAX_WIDTH = 128;
  localparam logic [MAX_WIDTH-1:0] DIV0_LO   = '1;

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step -- one iteration of the unsigned multiply/divide datapath.
// Build option: MULDIV_DIV_EN adds the restoring-divide step and the div_i port.
//   acc_i : {upper, lower} working register
//           multiply: {partial product, remaining multiplier bits}
//           divide  : {partial remainder, dividend bits / quotient bits}
//   b_i   : multiplicand (multiply) or divisor magnitude (divide)
//   div_i : select the divide step (only with MULDIV_DIV_EN)
//   acc_o : working register after this iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0]   b_i,
`ifdef MULDIV_DIV_EN
  input  logic               div_i,
`endif
  output logic [2*WIDTH-1:0] acc_o
);

  // Shift-add: conditionally add the multiplicand into the upper half,
  // then shift the whole register right, keeping the carry.
  logic [WIDTH:0] add_sum;
  assign add_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, b_i} : {(WIDTH+1){1'b0}});

`ifdef MULDIV_DIV_EN
  // Restoring divide: shift left by one, trial-subtract the divisor from the
  // upper WIDTH+1 bits; a set top bit means a borrow, so keep the shifted value.
  logic [WIDTH:0] trial;
  assign trial = acc_i[2*WIDTH-1:WIDTH-1] - {1'b0, b_i};

  always_comb begin
    acc_o = {add_sum, acc_i[WIDTH-1:1]};
    if (div_i) begin
      if (trial[WIDTH]) acc_o = {acc_i[2*WIDTH-2:0], 1'b0};
      else              acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
    end
  end
`else
  assign acc_o = {add_sum, acc_i[WIDTH-1:1]};
`endif

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer -- multi-cycle HI/LO multiply/divide unit for the EX stage.
// Build option: MULDIV_DIV_EN enables DIV/DIVU; without it ops 10/11 are ignored.
//   Clk, Rst_n     : clock, async active-low reset
//   start, op      : issue MULT/MULTU/DIV/DIVU (accepted only when idle)
//   opA, opB       : rs / rt operands
//   flush          : abort the in-flight op (wins over start and over DONE)
//   hilo_read      : ID stage wants HI/LO or issues another mult/div
//   busy           : op in flight (BUSY or DONE)
//   stall          : busy & hilo_read, to the hazard unit
//   done           : one-cycle pulse in the cycle HI/LO are written
//   hi, lo         : architectural HI/LO registers
// Timing: start edge -> WIDTH BUSY cycles -> one DONE cycle -> hi/lo valid.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  input  logic             hilo_read,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, step_acc;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               neg_q, neg_d;   // product / quotient must be negated
`ifdef MULDIV_DIV_EN
  logic               div_q, div_d;
  logic               rneg_q, rneg_d; // remainder takes the dividend's sign
  logic               bz_q, bz_d;     // divisor was zero
  logic [WIDTH-1:0]   opa_q, opa_d;   // raw dividend, returned in hi on /0
  logic [WIDTH-1:0]   quo, rem;
`endif

  logic               sgn, a_neg, b_neg, op_ok, accept;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] prod;

  // Signed ops are the even encodings (MULT, DIV).
  assign sgn   = ~op[0];
  assign a_neg = sgn & opA[WIDTH-1];
  assign b_neg = sgn & opB[WIDTH-1];
  assign a_mag = a_neg ? -opA : opA;
  assign b_mag = b_neg ? -opB : opB;

`ifdef MULDIV_DIV_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = ~op[1];
`endif

  assign accept = (state_q == S_IDLE) & start & ~flush & op_ok;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc_i (acc_q),
    .b_i   (b_q),
`ifdef MULDIV_DIV_EN
    .div_i (div_q),
`endif
    .acc_o (step_acc)
  );

  assign prod = neg_q ? -acc_q : acc_q;
`ifdef MULDIV_DIV_EN
  assign quo = neg_q  ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
  assign rem = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    neg_d   = neg_q;
`ifdef MULDIV_DIV_EN
    div_d   = div_q;
    rneg_d  = rneg_q;
    bz_d    = bz_q;
    opa_d   = opa_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_BUSY;
          cnt_d   = CW'(WIDTH-1);
          neg_d   = a_neg ^ b_neg;
          // Multiply shifts the multiplier (opB) out of the low half.
          acc_d   = {{WIDTH{1'b0}}, b_mag};
          b_d     = a_mag;
`ifdef MULDIV_DIV_EN
          div_d   = op[1];
          rneg_d  = a_neg;
          bz_d    = (opB == '0);
          opa_d   = opA;
          if (op[1]) begin
            // Divide shifts the dividend into the remainder half.
            acc_d = {{WIDTH{1'b0}}, a_mag};
            b_d   = b_mag;
          end
`endif
        end
      end
      S_BUSY: begin
        if (flush) begin
          state_d = S_IDLE;
        end else begin
          acc_d = step_acc;
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        if (!flush) begin
          {hi_d, lo_d} = prod;
`ifdef MULDIV_DIV_EN
          if (div_q) begin
            lo_d = bz_q ? DIV0_LO[WIDTH-1:0] : quo;
            hi_d = bz_q ? opa_q : rem;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      neg_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      div_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bz_q    <= 1'b0;
      opa_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      neg_q   <= neg_d;
`ifdef MULDIV_DIV_EN
      div_q   <= div_d;
      rneg_q  <= rneg_d;
      bz_q    <= bz_d;
      opa_q   <= opa_d;
`endif
    end
  end

  assign busy  = (state_q != S_IDLE);
  assign stall = busy & hilo_read;
  // A flush in DONE suppresses the write, so it also suppresses the pulse.
  assign done  = (state_q == S_DONE) & ~flush;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer -- randomized self-checking bench for muldiv_sequencer.
// Expected HI/LO come from plain 64-bit / integer arithmetic; divide tests
// are built only with MULDIV_DIV_EN, otherwise the no-op behaviour is checked.
module tb_muldiv_sequencer;
  localparam int W = 32;

  logic         Clk = 1'b0, Rst_n = 1'b0, start = 1'b0, flush = 1'b0, hilo_read = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] opA = '0, opB = '0;
  logic         busy, stall, done;
  logic [W-1:0] hi, lo;

  int checks = 0, errors = 0;

  // Reference HI/LO state and results of the last do_op.
  logic [W-1:0] m_hi = '0, m_lo = '0;
  int           r_dn, r_dcnt, r_idle;
  logic [W-1:0] r_hi, r_lo, r_dhi, r_dlo;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .start(start), .op(op), .opA(opA), .opB(opB),
    .flush(flush), .hilo_read(hilo_read), .busy(busy), .stall(stall),
    .done(done), .hi(hi), .lo(lo)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [63:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (o == 2'b00) begin sa = longint'($signed(a)); sb = longint'($signed(b)); end
    else begin sa = longint'({32'b0, a}); sb = longint'({32'b0, b}); end
    return 64'(sa * sb);
  endfunction

  function automatic logic [63:0] ref_div(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int sa, sb, q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (o == 2'b11) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    sa = $signed(a); sb = $signed(b);
    q = sa / sb; r = sa % sb;
    return {r, q};
  endfunction

  // Issue one op (caller sits just after a rising edge) and follow it until idle.
  // r_dn: edges after the start edge at which done was seen; r_idle: first idle.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start = 1'b1; op = o; opA = a; opB = b;
    @(posedge Clk); #1;
    start = 1'b0;
    r_dn = -1; r_dcnt = 0; r_idle = -1; r_dhi = 'x; r_dlo = 'x;
    for (int n = 0; n <= W + 5; n++) begin
      @(negedge Clk);
      if (done) begin r_dcnt++; r_dn = n; r_dhi = hi; r_dlo = lo; end
      if (!busy) begin r_idle = n; break; end
      @(posedge Clk); #1;
    end
    r_hi = hi; r_lo = lo;
    @(posedge Clk); #1;
  endtask

  task automatic test_reset();
    hilo_read = 1'b1; Rst_n = 1'b0;
    #2;
    checks++; if ({busy, stall, done} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got %b want 000", {busy, stall, done}); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo got %h want 0", {hi, lo}); end
    @(negedge Clk); Rst_n = 1'b1;
    @(posedge Clk); #1;
    hilo_read = 1'b0;
  endtask

  task automatic test_mult_directed();
    logic [W-1:0] ph, pl;
    ph = m_hi; pl = m_lo;
    do_op(2'b00, -32'sd3, 32'd7);
    {m_hi, m_lo} = {32'hFFFF_FFFF, 32'hFFFF_FFEB};
    checks++; if (r_dcnt !== 1 || r_dn !== W) begin errors++; $display("FAIL mult_done got cnt=%0d at=%0d want 1 at %0d", r_dcnt, r_dn, W); end
    checks++; if (r_idle !== W + 1) begin errors++; $display("FAIL mult_latency got %0d want %0d", r_idle, W + 1); end
    checks++; if ({r_dhi, r_dlo} !== {ph, pl}) begin errors++; $display("FAIL mult_early_write got %h want %h", {r_dhi, r_dlo}, {ph, pl}); end
    checks++; if ({r_hi, r_lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL mult_neg3x7 got %h want %h", {r_hi, r_lo}, {m_hi, m_lo}); end
  endtask

  task automatic test_mult_random();
    logic [1:0] o; logic [W-1:0] a, b;
    for (int i = 0; i < 10; i++) begin
      o = 2'($urandom_range(0, 1)); a = $urandom; b = $urandom;
      if (i == 0) begin a = 32'h8000_0000; b = 32'h8000_0000; end
      if (i == 1) begin a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
      if (i == 2) begin a = 32'h0; end
      do_op(o, a, b);
      {m_hi, m_lo} = ref_mul(o, a, b);
      checks++; if ({r_hi, r_lo} !== {m_hi, m_lo} || r_idle !== W + 1 || r_dcnt !== 1)
        begin errors++; $display("FAIL mult_rand op=%0d a=%h b=%h got %h idle=%0d done=%0d want %h idle=%0d done=1", o, a, b, {r_hi, r_lo}, r_idle, r_dcnt, {m_hi, m_lo}, W + 1); end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] a, b;
    logic exp_stall;
    a = $urandom; b = $urandom;
    start = 1'b1; op = 2'b01; opA = a; opB = b;
    @(posedge Clk); #1;
    start = 1'b0;
    for (int n = 0; n <= W + 1; n++) begin
      if (n == 3) hilo_read = 1'b1;
      // Second request while busy must be ignored.
      if (n == 5) begin start = 1'b1; op = 2'b00; opA = $urandom; opB = $urandom; end
      else start = 1'b0;
      @(negedge Clk);
      exp_stall = (n >= 3 && n <= W);
      checks++; if (stall !== exp_stall) begin errors++; $display("FAIL stall_cyc%0d got %b want %b", n, stall, exp_stall); end
      @(posedge Clk); #1;
    end
    start = 1'b0; hilo_read = 1'b0;
    {m_hi, m_lo} = ref_mul(2'b01, a, b);
    @(negedge Clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stall_second_start got busy=%b want 0", busy); end
    checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL stall_result got %h want %h", {hi, lo}, {m_hi, m_lo}); end
    @(posedge Clk); #1;
  endtask

  task automatic test_flush();
    int seen;
    // Flush mid-BUSY.
    seen = 0;
    start = 1'b1; op = 2'b00; opA = $urandom; opB = $urandom;
    @(posedge Clk); #1;
    start = 1'b0;
    for (int n = 0; n <= 10; n++) begin
      if (n == 10) flush = 1'b1;
      @(negedge Clk);
      if (done) seen++;
      @(posedge Clk); #1;
    end
    flush = 1'b0;
    @(negedge Clk);
    checks++; if (busy !== 1'b0 || seen !== 0) begin errors++; $display("FAIL flush_busy got busy=%b done=%0d want 0 0", busy, seen); end
    checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL flush_busy_hilo got %h want %h", {hi, lo}, {m_hi, m_lo}); end
    @(posedge Clk); #1;
    // Flush in DONE.
    seen = 0;
    start = 1'b1; op = 2'b01; opA = $urandom | 32'h1; opB = $urandom | 32'h1;
    @(posedge Clk); #1;
    start = 1'b0;
    for (int n = 0; n <= W; n++) begin
      if (n == W) flush = 1'b1;
      @(negedge Clk);
      if (done) seen++;
      @(posedge Clk); #1;
    end
    flush = 1'b0;
    @(negedge Clk);
    checks++; if (busy !== 1'b0 || seen !== 0) begin errors++; $display("FAIL flush_done got busy=%b done=%0d want 0 0", busy, seen); end
    checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL flush_done_hilo got %h want %h", {hi, lo}, {m_hi, m_lo}); end
    @(posedge Clk); #1;
    // Start together with flush in IDLE.
    start = 1'b1; flush = 1'b1; op = 2'b00; opA = $urandom; opB = $urandom;
    @(posedge Clk); #1;
    start = 1'b0; flush = 1'b0;
    @(negedge Clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_start got busy=%b want 0", busy); end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] a, b;
    hilo_read = 1'b1;
    start = 1'b1; op = 2'b00; opA = $urandom; opB = $urandom;
    @(posedge Clk); #1;
    start = 1'b0;
    for (int n = 0; n < 20; n++) begin @(posedge Clk); #1; end
    Rst_n = 1'b0;
    #1;
    checks++; if ({busy, stall, done} !== 3'b000) begin errors++; $display("FAIL rst_mid_ctrl got %b want 000", {busy, stall, done}); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rst_mid_hilo got %h want 0", {hi, lo}); end
    {m_hi, m_lo} = '0;
    @(negedge Clk); Rst_n = 1'b1;
    @(posedge Clk); #1;
    hilo_read = 1'b0;
    a = $urandom; b = $urandom;
    do_op(2'b00, a, b);
    {m_hi, m_lo} = ref_mul(2'b00, a, b);
    checks++; if ({r_hi, r_lo} !== {m_hi, m_lo} || r_idle !== W + 1 || r_dcnt !== 1)
      begin errors++; $display("FAIL rst_then_op got %h idle=%0d done=%0d want %h idle=%0d done=1", {r_hi, r_lo}, r_idle, r_dcnt, {m_hi, m_lo}, W + 1); end
  endtask

`ifdef MULDIV_DIV_EN
  task automatic test_div();
    logic [1:0] o; logic [W-1:0] a, b;
    for (int i = 0; i < 14; i++) begin
      o = 2'($urandom_range(2, 3)); a = $urandom; b = $urandom >> $urandom_range(0, 31);
      case (i)
        0: begin o = 2'b11; a = 32'd100;        b = 32'd7;          end
        1: begin o = 2'b10; a = -32'sd7;        b = 32'd2;          end
        2: begin o = 2'b10; a = 32'd5;          b = 32'd0;          end
        3: begin o = 2'b10; a = 32'h8000_0000;  b = 32'hFFFF_FFFF;  end
        4: begin o = 2'b11; a = 32'hDEAD_BEEF;  b = 32'd0;          end
        5: begin o = 2'b10; a = 32'd7;          b = -32'sd2;        end
        default: ;
      endcase
      do_op(o, a, b);
      {m_hi, m_lo} = ref_div(o, a, b);
      checks++; if ({r_hi, r_lo} !== {m_hi, m_lo} || r_idle !== W + 1 || r_dcnt !== 1)
        begin errors++; $display("FAIL div op=%0d a=%h b=%h got %h idle=%0d done=%0d want %h idle=%0d done=1", o, a, b, {r_hi, r_lo}, r_idle, r_dcnt, {m_hi, m_lo}, W + 1); end
    end
  endtask
`else
  task automatic test_div_noop();
    for (int k = 0; k < 2; k++) begin
      hilo_read = 1'b1;
      start = 1'b1; op = (k == 0) ? 2'b10 : 2'b11; opA = $urandom; opB = $urandom;
      @(posedge Clk); #1;
      start = 1'b0;
      for (int n = 0; n < 3; n++) begin
        @(negedge Clk);
        checks++; if ({busy, stall, done} !== 3'b000) begin errors++; $display("FAIL div_noop op=%0d cyc%0d got %b want 000", op, n, {busy, stall, done}); end
        @(posedge Clk); #1;
      end
      hilo_read = 1'b0;
      checks++; if ({hi, lo} !== {m_hi, m_lo}) begin errors++; $display("FAIL div_noop_hilo got %h want %h", {hi, lo}, {m_hi, m_lo}); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_mult_directed();
    test_mult_random();
    test_stall();
    test_flush();
    test_reset_mid();
`ifdef MULDIV_DIV_EN
    test_div();
`else
    test_div_noop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
